// File: rtl/forward_ctrl.sv
// forward_ctrl: operand-forwarding and load-use stall control for the
// five-stage pipelined CPU.
//
// Keeps a shadow copy of the register-index / write-enable information for
// the EX, MEM and WB stages. From it, this block produces:
//   - the ALU operand-mux selects (00 = regfile, 01 = EX/MEM, 10 = MEM/WB)
//   - a one-cycle load-use stall
//   - a saturating count of stall cycles
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   id_rs_i, id_rt_i     source registers of the instruction in ID
//   id_rd_i              destination register of the instruction in ID
//   id_regwrite_i        instruction in ID writes the register file
//   id_memread_i         instruction in ID is a load
//   flush_i              squash the instruction in ID
//   fwd_a_o, fwd_b_o     operand A / B forwarding selects
//   stall_o              hold PC and IF/ID this cycle
//   stall_cnt_o          saturating count of stall cycles
module forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } ex_stage_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } mem_stage_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } wb_stage_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  ex_stage_t  ex_q;
  mem_stage_t mem_q;
  wb_stage_t  wb_q;
  state_t     state;
  logic       hazard;

  // Pick the youngest in-flight producer of src; register 0 is hardwired zero.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input mem_stage_t m,
                                         input wb_stage_t w);
    if (m.regwrite && (m.rd != '0) && (m.rd == src))
      return 2'b01;
    else if (w.regwrite && (w.rd != '0) && (w.rd == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a_o = fwd_sel(ex_q.rs, mem_q, wb_q);
    fwd_b_o = fwd_sel(ex_q.rt, mem_q, wb_q);
  end

  // A load in EX cannot forward its data yet; the dependent in ID has to wait
  // one cycle. A flushed ID instruction never executes, so it needs no stall.
  always_comb begin
    hazard  = ex_q.memread && ex_q.regwrite && (ex_q.rd != '0) &&
              ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));
    stall_o = hazard && !flush_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state       <= RUN;
      stall_cnt_o <= '0;
    end else begin
      wb_q  <= '{rd: mem_q.rd, regwrite: mem_q.regwrite};
      mem_q <= '{rd: ex_q.rd, regwrite: ex_q.regwrite, memread: ex_q.memread};
      // A stalled or squashed instruction leaves a bubble behind in EX.
      if (stall_o || flush_i)
        ex_q <= '0;
      else
        ex_q <= '{rs: id_rs_i, rt: id_rt_i, rd: id_rd_i,
                  regwrite: id_regwrite_i, memread: id_memread_i};

      if (stall_o && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + 1'b1;

      // The bubble inserted on the stall edge clears the hazard, so STALL
      // always lasts exactly one cycle.
      case (state)
        RUN:     if (stall_o) state <= STALL;
        STALL:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // A load-use stall never lasts longer than one cycle.
  a_single_stall: assert property (@(posedge clk_i) disable iff (rst_i)
                                   (state == STALL) |-> !stall_o);

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] rs, rt, rd;
  logic             rw, mr, fl;
  logic [1:0]       fa, fb;
  logic             st;
  logic [CNT_W-1:0] cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  forward_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(rs), .id_rt_i(rt), .id_rd_i(rd),
    .id_regwrite_i(rw), .id_memread_i(mr), .flush_i(fl),
    .fwd_a_o(fa), .fwd_b_o(fb), .stall_o(st), .stall_cnt_o(cnt)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt, rd;
    logic       rw, mr, fl;
    logic       chk;
    logic [1:0] fa, fb;
    logic       st;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input int s, input int t, input int d,
                     input logic w, input logic m, input logic f, input logic c,
                     input logic [1:0] efa, input logic [1:0] efb,
                     input logic est, input int ecnt);
    vec_t v;
    v.rst = r; v.rs = 5'(s); v.rt = 5'(t); v.rd = 5'(d);
    v.rw = w; v.mr = m; v.fl = f; v.chk = c;
    v.fa = efa; v.fb = efb; v.st = est; v.cnt = 4'(ecnt);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Apply ID inputs for one cycle; outputs are sampled mid-cycle, before the edge.
  task automatic drive(input logic r, input int s, input int t, input int d,
                       input logic w, input logic m, input logic f);
    @(negedge clk);
    rst = r; rs = 5'(s); rt = 5'(t); rd = 5'(d); rw = w; mr = m; fl = f;
    #2;
  endtask

  initial begin
    rst = 1'b1; rs = '0; rt = '0; rd = '0; rw = 1'b0; mr = 1'b0; fl = 1'b0;

    //   rst rs rt rd rw mr fl chk  fa     fb    st cnt
    row(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0); // reset
    // add $3,$1,$2 ; sub $4,$3,$5 -> EX/MEM forward on A
    row(0, 1, 2, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 3, 5, 4, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    // add $3 ; nop ; or $6,$7,$3 -> MEM/WB forward on B
    row(0, 1, 2, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 7, 3, 6, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0);
    // add $3 ; add $3 ; and $8,$3,$3 -> MEM wins over WB
    row(0, 1, 2, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 4, 5, 3, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 3, 3, 8, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 0, 0);
    // writer of $0 ; consumer of $0 -> never forwarded
    row(0, 1, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 0, 0, 9, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    // lw $2,0($1) ; add $4,$2,$5 -> one stall, then MEM/WB forward
    row(0, 1, 2, 2, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 2, 5, 4, 1, 0, 0, 1, 2'b00, 2'b00, 1, 0);
    row(0, 2, 5, 4, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 1);
    // same load-use, consumer flushed -> no stall, count unchanged
    row(0, 1, 2, 2, 1, 1, 0, 1, 2'b00, 2'b00, 0, 1);
    row(0, 2, 5, 4, 1, 0, 1, 1, 2'b00, 2'b00, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1);
    // reset asserted in the stall cycle
    row(0, 1, 2, 2, 1, 1, 0, 1, 2'b00, 2'b00, 0, 1);
    row(1, 2, 5, 4, 1, 0, 0, 1, 2'b00, 2'b00, 1, 1);
    row(0, 2, 5, 4, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);
    row(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, int'(tbl[i].rs), int'(tbl[i].rt), int'(tbl[i].rd),
            tbl[i].rw, tbl[i].mr, tbl[i].fl);
      if (tbl[i].chk) begin
        check("fwd_a", i, int'(fa), int'(tbl[i].fa));
        check("fwd_b", i, int'(fb), int'(tbl[i].fb));
        check("stall", i, int'(st), int'(tbl[i].st));
        check("stall_cnt", i, int'(cnt), int'(tbl[i].cnt));
      end
    end

    // Counter saturation: 2^CNT_W + 3 load-use stalls, count pins at 15.
    for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
      drive(0, 1, 2, 2, 1, 1, 0);          // lw $2
      drive(0, 2, 5, 4, 1, 0, 0);          // add $4,$2,$5 -> stall
      check("sat_stall", n, int'(st), 1);
      check("sat_cnt_pre", n, int'(cnt), (n < 15) ? n : 15);
      drive(0, 2, 5, 4, 1, 0, 0);          // held consumer proceeds
      check("sat_no_stall", n, int'(st), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("sat_final", 0, int'(cnt), 15);

    // Reset clears a saturated counter.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rst_cnt", 0, int'(cnt), 0);
    check("rst_stall", 0, int'(st), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Produces the 2-bit select codes that drive the ALU-operand 3-to-1 forwarding muxes in the lab4 pipelined CPU. Both muxes take data0 = register-file value, data1 = EX/MEM ALU result, data2 = MEM/WB write-back value.
- Keeps its own shadow pipeline of destination-register and write-enable info for the EX, MEM and WB stages.
- Detects load-use hazards, raises a one-cycle stall and injects a bubble.
- Counts stall cycles for performance statistics.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, stall-counter width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- id_rs_i  input  REG_W  rs of instruction currently in ID.
- id_rt_i  input  REG_W  rt of instruction currently in ID.
- id_rd_i  input  REG_W  destination register of instruction in ID (already muxed rd/rt).
- id_regwrite_i  input  1  instruction in ID writes the register file.
- id_memread_i  input  1  instruction in ID is a load.
- flush_i  input  1  squash the instruction in ID (taken branch/jump).
- fwd_a_o  output  2  select for operand-A mux.
- fwd_b_o  output  2  select for operand-B mux.
- stall_o  output  1  hold PC and IF/ID this cycle.
- stall_cnt_o  output  CNT_W  number of stall cycles since reset.

Behaviour:
- Shadow stages:
  - EX holds {rs, rt, rd, regwrite, memread}.
  - MEM holds {rd, regwrite, memread}.
  - WB holds {rd, regwrite}.
- Every edge:
  - WB <= MEM; MEM <= EX.
  - EX <= ID inputs, or a bubble (all fields zero) when stall_o=1 or flush_i=1.
  - There is no global freeze.
- Reset: all stage fields 0 (bubble), stall_cnt_o=0. Consequently fwd_a_o=fwd_b_o=2'b00 and stall_o=0 in the cycle after reset.
- Forward select (combinational from stage registers, zero latency). For fwd_a_o use EX.rs:
  - 2'b01 if MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs.
  - else 2'b10 if WB.regwrite & WB.rd!=0 & WB.rd==EX.rs.
  - else 2'b00.
  - fwd_b_o is identical using EX.rt.
  - MEM has priority over WB (youngest value wins). Register 0 is never forwarded. Code 2'b11 is never produced.
- Load-use hazard (combinational):
  - hazard = EX.memread & EX.regwrite & EX.rd!=0 & (EX.rd==id_rs_i | EX.rd==id_rt_i).
  - stall_o = hazard & ~flush_i. A flush squashes the ID instruction, so no stall is needed.
- Stall FSM, two states:
  - RUN -> STALL on stall_o=1.
  - STALL -> RUN unconditionally. The bubble now in EX clears the hazard, and the load has moved to MEM.
  - stall_o is never asserted in STALL. This is an assertion target: maximum stall length is 1 cycle.
- After the stall, the consumer sits in EX with the load in WB, so it forwards with code 2'b10 (load data via MEM/WB).
- stall_cnt_o increments on each edge where stall_o=1 and saturates at all-ones; it never wraps.
- Reset mid-stall: state returns to RUN, stages are cleared and the counter clears. Synchronous reset overrides all other inputs that edge.

Test Plan:
- Reset, then add $3,$1,$2 followed by sub $4,$3,$5 → fwd_a_o=2'b01 in the cycle sub is in EX. fwd_b_o=2'b00, stall_o never 1.
- add $3; nop; or $6,$7,$3 → fwd_b_o=2'b10 when or is in EX.
- add $3; add $3; and $8,$3,$3 → fwd_a_o=fwd_b_o=2'b01 (MEM priority over WB).
- Writer to $0 followed by a consumer of $0 → both selects 2'b00.
- lw $2,0($1) followed by add $4,$2,$5 → stall_o=1 for exactly one cycle and a bubble enters EX. add then gets fwd_a_o=2'b10, and stall_cnt_o=1.
- Same load-use with flush_i=1 in the hazard cycle → stall_o=0 and stall_cnt_o unchanged.
- Assert rst_i during a stall → next cycle stall_o=0, selects 2'b00, stall_cnt_o=0.
- Force 2^CNT_W+3 stalls (CNT_W=4 override) → counter holds at 15.
